pe_ctx_seq: RTL and testbench
=============================

// Module: pe_ctx_seq
// PURPOSE
// - Next-generation CGRA processing element: NUM_IN-bus PE with a CTX_DEPTH-entry context memory and a sequencer.
// - Without reconfiguration between ops, it steps one context per cycle, optionally looping.
// - Sits in the PE array in place of the single-configuration 6-bus PE; bus order is 0=up 1=down 2=left 3=right 4=bypass_1 5=bypass_2.
// PARAMETERS
// - DW         32  data width of every bus
// - NUM_IN     6   number of input/output buses
// - CTX_DEPTH  8   context memory entries (power of 2)
// - SELW       $clog2(NUM_IN+1) (localparam)  operand-select width
// - CTXW       2*SELW+4+NUM_IN+1 (localparam)  context word width; 17 at defaults
// PORTS
// - clk        in   1                 single clock, rising edge
// - rst        in   1                 reset: synchronous, active-low; the block resets on a clk edge while rst==0
// - din        in   NUM_IN*DW         input buses, bus i = din[i*DW +: DW]
// - dout       out  NUM_IN*DW         registered output buses, same packing
// - cfg_we     in   1                 context write enable
// - cfg_addr   in   $clog2(CTX_DEPTH) context write address
// - cfg_data   in   CTXW              context word
// - last_ctx   in   $clog2(CTX_DEPTH) index of final context in the program (sampled at start)
// - loop_en    in   1                 1 = wrap to ctx 0 after last_ctx (sampled at start)
// - start      in   1                 begin program; honoured in IDLE only
// - stop       in   1                 abort run
// - busy       out  1                 state==RUN
// - done       out  1                 one-cycle pulse at normal program end
// - iter_cnt   out  16                completed passes of the current run, wraps at 2^16
// BEHAVIOUR
// - Context word fields, LSB first: sel_a[SELW], sel_b[SELW], op[4], out_en[NUM_IN], acc_en[1].
// - Operand select: code < NUM_IN selects din bus; code == NUM_IN selects internal acc register; greater codes select 0.
// - op: 0 PASS a, 1 ADD, 2 SUB a-b, 3 MUL low DW bits, 4 AND, 5 OR, 6 XOR, 7 SHL a<<b[4:0], 8 SHR logical, 9 LTU (1/0), 10 MAXU, 11 MINU, 12-15 result 0.
// - All arithmetic is unsigned modulo 2^DW; no flags are generated.
// - Reset (rst==0 at edge) clears:
//   - dout, acc, pc and iter_cnt to 0; busy and done to 0; state to IDLE;
//   - every context entry to 0 (PASS, out_en=0, which has no effect).
// - FSM IDLE:
//   - start=1 at edge T: latch last_ctx and loop_en, pc<=0, state<=RUN, iter_cnt<=0.
//   - Otherwise outputs hold.
// - FSM RUN, each edge:
//   - Execute ctx[pc]: result = ALU(sel_a, sel_b, op).
//   - dout[i] <= result where out_en[i]=1; other buses hold.
//   - acc <= result if acc_en.
//   - Latency: din sampled at edge T+1 for ctx0 (start at T) appears on dout after edge T+1, i.e. one cycle.
// - pc control in RUN:
//   - pc != last: pc <= pc+1.
//   - pc == last && loop_en: pc <= 0 and iter_cnt <= iter_cnt+1.
//   - pc == last && !loop_en: state <= IDLE, done <= 1 for one cycle, iter_cnt <= 1.
// - stop=1 in RUN: the current context still executes; state <= IDLE; done stays 0; iter_cnt holds.
// - stop=1 in IDLE: no effect.
// - start and stop together in IDLE: start wins, because stop is only honoured in RUN.
// - start in RUN: ignored.
// - cfg_we is allowed in any state. A write to the address being executed that cycle takes effect on the next visit (read-before-write).
// - last_ctx >= CTX_DEPTH is impossible by width.
// - last_ctx=0 with loop_en: ctx0 repeats every cycle.
// - Reset mid-RUN: aborts with full reset values; done is not pulsed.
// STRUCTURE
// - Shared package pe_pkg:
//   - opcode localparams (OP_PASS..OP_MINU);
//   - context field offsets and widths;
//   - FSM state encoding (ST_IDLE, ST_RUN).
// - Sub-module pe_alu: combinational, parameter DW, ports a, b, op, y. One instance.
// - Operand muxes, context memory (register array), sequencer and output registers live in pe_ctx_seq.
// TESTING
// - Reset: hold rst=0 for 2 edges with din nonzero -> dout all 0, busy=0, done=0, iter_cnt=0.
// - Single ADD: ctx0 = {sel_a=0, sel_b=2, op=1, out_en=6'b000001}, last_ctx=0, loop_en=0, up=5, left=7; pulse start -> next cycle dout_up=12; done=1 for exactly one cycle; busy back to 0; other buses stay 0.
// - Accumulate loop:
//   - Setup: ctx0 = {sel_a=6(acc), sel_b=4, op=1, acc_en=1, out_en=6'b010000}, loop_en=1, bypass_1 held at 9, start.
//   - Required: dout_bypass_1 = 9, 18, 27, ... on successive cycles, with iter_cnt incrementing every cycle.
//   - Assert stop -> IDLE, done stays 0, values hold.
// - Width rules:
//   - MUL 32'h0001_0000 * 32'h0001_0000 -> 0.
//   - SHL 1 by 33 -> 2.
//   - SUB 3-5 -> 32'hFFFF_FFFE.
//   - LTU 3,5 -> 1.
//   - Sel code 7 -> operand 0.
// - Live rewrite: 3-context loop (PASS up, PASS down, PASS left to dout_right). Write ctx1 to op=XOR while pc==1 -> that cycle produces PASS; the next pass produces XOR.
// - Reset mid-RUN: rst=0 during a looping run -> next cycle busy=0, dout=0, no done. A subsequent start with no context loads leaves dout at 0.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared opcodes, context-word layout helpers and FSM state encoding for the context-sequenced PE.
package pe_pkg;
  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_LTU  = 4'd9;
  localparam logic [3:0] OP_MAXU = 4'd10;
  localparam logic [3:0] OP_MINU = 4'd11;
  localparam int OP_W  = 4;
  localparam int ACC_W = 1;
  function automatic int sel_w(input int num_in);
    return $clog2(num_in + 1);
  endfunction
  function automatic int ctx_w(input int num_in);
    return 2 * sel_w(num_in) + OP_W + num_in + ACC_W;
  endfunction
  function automatic int off_sel_b(input int num_in);
    return sel_w(num_in);
  endfunction
  function automatic int off_op(input int num_in);
    return 2 * sel_w(num_in);
  endfunction
  function automatic int off_out_en(input int num_in);
    return 2 * sel_w(num_in) + OP_W;
  endfunction
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/pe_ctx_seq_if.sv
// pe_ctx_seq_if: data buses, context-load port and sequencer control/status of one PE.
interface pe_ctx_seq_if #(parameter int DW = 32, parameter int NUM_IN = 6, parameter int CTX_DEPTH = 8);
  import pe_pkg::*;
  localparam int CTXW = ctx_w(NUM_IN);
  localparam int AW = $clog2(CTX_DEPTH);
  logic [NUM_IN*DW-1:0] din;
  logic [NUM_IN*DW-1:0] dout;
  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic [CTXW-1:0]      cfg_data;
  logic [AW-1:0]        last_ctx;
  logic                 loop_en;
  logic                 start;
  logic                 stop;
  logic                 busy;
  logic                 done;
  logic [15:0]          iter_cnt;
  modport master(output din, cfg_we, cfg_addr, cfg_data, last_ctx, loop_en, start, stop,
                 input dout, busy, done, iter_cnt);
  modport slave(input din, cfg_we, cfg_addr, cfg_data, last_ctx, loop_en, start, stop,
                output dout, busy, done, iter_cnt);
endinterface

// File: rtl/pe_alu.sv
// pe_alu: unsigned modulo-2^DW ALU executing one context opcode.
module pe_alu import pe_pkg::*; #(parameter int DW = 32) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    op,
    output logic [DW-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            OP_PASS: y = a;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = a * b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL:  y = a << b[4:0];
            OP_SHR:  y = a >> b[4:0];
            OP_LTU:  y = {{(DW-1){1'b0}}, a < b};
            OP_MAXU: y = a > b ? a : b;
            OP_MINU: y = a < b ? a : b;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/pe_ctx_seq.sv
// pe_ctx_seq: CGRA PE stepping one context per cycle through a small context memory,
// optionally looping, with registered output buses and an internal accumulator.
module pe_ctx_seq import pe_pkg::*; #(
    parameter int DW = 32,
    parameter int NUM_IN = 6,
    parameter int CTX_DEPTH = 8
) (
    input logic         clk,
    input logic         rst,
    pe_ctx_seq_if.slave bus
);
    localparam int SELW = sel_w(NUM_IN);
    localparam int CTXW = ctx_w(NUM_IN);
    localparam int AW = $clog2(CTX_DEPTH);
    state_t state, state_nx;
    logic [CTXW-1:0] ctx [CTX_DEPTH];
    logic [CTXW-1:0] cw;
    logic [AW-1:0] pc, last_q;
    logic loop_q, run, at_last, done_q;
    logic [DW-1:0] acc, a, b, y;
    logic [NUM_IN*DW-1:0] dout_q;
    logic [15:0] iter_q;
    logic [SELW-1:0] sel_a, sel_b;
    logic [3:0] op;
    logic [NUM_IN-1:0] out_en;
    logic acc_en;
    assign cw     = ctx[pc];
    assign sel_a  = cw[SELW-1:0];
    assign sel_b  = cw[off_sel_b(NUM_IN) +: SELW];
    assign op     = cw[off_op(NUM_IN) +: OP_W];
    assign out_en = cw[off_out_en(NUM_IN) +: NUM_IN];
    assign acc_en = cw[CTXW-1];
    assign run     = state == ST_RUN;
    assign at_last = pc == last_q;
    // Code NUM_IN picks the accumulator; anything above reads as zero.
    always_comb begin
        a = sel_a < NUM_IN ? bus.din[sel_a*DW +: DW] : sel_a == NUM_IN ? acc : '0;
        b = sel_b < NUM_IN ? bus.din[sel_b*DW +: DW] : sel_b == NUM_IN ? acc : '0;
    end
    pe_alu #(.DW(DW)) u_alu (.a(a), .b(b), .op(op), .y(y));
    always_comb begin
        state_nx = state;
        state_nx = (state == ST_IDLE && bus.start) ? ST_RUN
                 : (run && (bus.stop || (at_last && !loop_q))) ? ST_IDLE : state;
    end
    always_ff @(posedge clk)
        state <= !rst ? ST_IDLE : state_nx;
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= '0;
            last_q <= '0;
            loop_q <= 1'b0;
            iter_q <= '0;
            done_q <= 1'b0;
            acc <= '0;
            dout_q <= '0;
            for (int i = 0; i < CTX_DEPTH; i++) ctx[i] <= '0;
        end else begin
            done_q <= run && !bus.stop && at_last && !loop_q;
            if (bus.cfg_we) ctx[bus.cfg_addr] <= bus.cfg_data;
            if (state == ST_IDLE && bus.start) begin
                last_q <= bus.last_ctx;
                loop_q <= bus.loop_en;
                pc <= '0;
                iter_q <= '0;
            end
            if (run) begin
                for (int i = 0; i < NUM_IN; i++) if (out_en[i]) dout_q[i*DW +: DW] <= y;
                if (acc_en) acc <= y;
                if (!bus.stop) begin
                    if (!at_last) pc <= pc + 1'b1;
                    else if (loop_q) begin
                        pc <= '0;
                        iter_q <= iter_q + 16'd1;
                    end else iter_q <= 16'd1;
                end
            end
        end
    end
    assign bus.dout     = dout_q;
    assign bus.busy     = run;
    assign bus.done     = done_q;
    assign bus.iter_cnt = iter_q;
endmodule

// File: tb/tb_pe_ctx_seq.sv
// tb_pe_ctx_seq: directed-vector bench for pe_ctx_seq with hand-computed expectations.
module tb_pe_ctx_seq;
    import pe_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_fail = 0;
    pe_ctx_seq_if #(.DW(32), .NUM_IN(6), .CTX_DEPTH(8)) bus ();
    pe_ctx_seq #(.DW(32), .NUM_IN(6), .CTX_DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] mk(input int sa, input int sb, input int op, input logic [5:0] oe, input logic ae);
        logic [2:0] a3, b3;
        logic [3:0] o4;
        a3 = sa[2:0];
        b3 = sb[2:0];
        o4 = op[3:0];
        return {ae, oe, o4, b3, a3};
    endfunction

    function automatic logic [31:0] dbus(input int i);
        return bus.dout[i*32 +: 32];
    endfunction

    task automatic set_din(input logic [31:0] v0, v1, v2, v3, v4, v5);
        bus.din = {v5, v4, v3, v2, v1, v0};
    endtask

    task automatic load(input int addr, input logic [16:0] w);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = addr[2:0];
        bus.cfg_data = w;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic go(input int last, input logic lp);
        bus.last_ctx = last[2:0];
        bus.loop_en = lp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.last_ctx = '0;
        bus.loop_en = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        set_din(1, 2, 3, 4, 5, 6);
        tick();
        tick();
        chk("rst_dout_lo", bus.dout[63:0], 64'd0);
        chk("rst_dout_hi", {32'd0, bus.dout[191:160]} | {bus.dout[159:128], bus.dout[127:96]}, 64'd0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_iter", bus.iter_cnt, 0);
        rst = 1'b1;

        load(0, mk(0, 2, 1, 6'b000001, 1'b0));
        set_din(5, 0, 7, 0, 0, 0);
        go(0, 1'b0);
        chk("add_busy", bus.busy, 1);
        tick();
        chk("add_up", dbus(0), 12);
        chk("add_others", bus.dout[191:32] == '0, 1);
        chk("add_done", bus.done, 1);
        chk("add_busy_off", bus.busy, 0);
        chk("add_iter", bus.iter_cnt, 1);
        tick();
        chk("add_done_pulse", bus.done, 0);
        chk("add_hold", dbus(0), 12);

        load(0, mk(6, 4, 1, 6'b010000, 1'b1));
        set_din(0, 0, 0, 0, 9, 0);
        go(0, 1'b1);
        chk("acc_iter0", bus.iter_cnt, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("acc_val%0d", k), dbus(4), 9 * k);
            chk($sformatf("acc_iter%0d", k), bus.iter_cnt, k);
            chk($sformatf("acc_done%0d", k), bus.done, 0);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stop_busy", bus.busy, 0);
        chk("stop_done", bus.done, 0);
        chk("stop_val", dbus(4), 45);
        chk("stop_iter", bus.iter_cnt, 4);
        tick();
        chk("stop_hold", dbus(4), 45);
        chk("stop_done2", bus.done, 0);

        load(0, mk(0, 0, 3, 6'b000001, 1'b0));
        load(1, mk(1, 2, 7, 6'b000010, 1'b0));
        load(2, mk(3, 4, 2, 6'b000100, 1'b0));
        load(3, mk(3, 4, 9, 6'b001000, 1'b0));
        load(4, mk(7, 7, 0, 6'b110000, 1'b0));
        load(5, mk(3, 4, 10, 6'b100000, 1'b0));
        set_din(32'h0001_0000, 1, 33, 3, 5, 32'hdead);
        go(5, 1'b0);
        for (int k = 0; k < 6; k++) tick();
        chk("w_mul", dbus(0), 0);
        chk("w_shl", dbus(1), 2);
        chk("w_sub", dbus(2), 32'hFFFF_FFFE);
        chk("w_ltu", dbus(3), 1);
        chk("w_sel7", dbus(4), 0);
        chk("w_maxu", dbus(5), 5);
        chk("w_done", bus.done, 1);

        load(0, mk(0, 0, 0, 6'b001000, 1'b0));
        load(1, mk(1, 0, 0, 6'b001000, 1'b0));
        load(2, mk(2, 0, 0, 6'b001000, 1'b0));
        set_din(32'h11, 32'h22, 32'h0F, 0, 0, 0);
        go(2, 1'b1);
        tick();
        chk("lr_p0", dbus(3), 32'h11);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 3'd1;
        bus.cfg_data = mk(1, 2, 6, 6'b001000, 1'b0);
        tick();
        bus.cfg_we = 1'b0;
        chk("lr_old", dbus(3), 32'h22);
        tick();
        chk("lr_p2", dbus(3), 32'h0F);
        chk("lr_iter", bus.iter_cnt, 1);
        tick();
        chk("lr_p0b", dbus(3), 32'h11);
        tick();
        chk("lr_xor", dbus(3), 32'h2D);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mr_busy", bus.busy, 0);
        chk("mr_dout", bus.dout == '0, 1);
        chk("mr_done", bus.done, 0);
        chk("mr_iter", bus.iter_cnt, 0);
        go(0, 1'b0);
        tick();
        chk("mr_ctx_clear", bus.dout == '0, 1);
        chk("mr_done2", bus.done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
